// File: rtl/simon_input_ctrl.sv
// Key-entry front end for the Simon game: arms on request, debounces one key press
// and its release, echoes the held key on the lamps and reports it over valid/ready.
module simon_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 150000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] pressed,
  input  logic       arm,
  output logic       event_valid,
  output logic [1:0] event_button,
  input  logic       event_ready,
  output logic       timeout,
  output logic [3:0] lamp,
  output logic       busy
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RELEASE,
    WAIT_PRESS,
    DEBOUNCE_PRESS,
    WAIT_UP,
    REPORT
  } state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] deb_cnt_reg, deb_cnt_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic [3:0]    code_reg, code_next;

  logic          any_key;
  logic          one_hot;
  logic [DW-1:0] deb_inc;
  logic [TW-1:0] to_inc;
  logic [1:0]    code_index;

  assign any_key = |pressed;
  assign one_hot = any_key && ((pressed & (pressed - 4'd1)) == 4'd0);

  // Saturating increments: neither counter may wrap back to zero.
  assign deb_inc = (deb_cnt_reg >= DEB_MAX) ? deb_cnt_reg : deb_cnt_reg + DEB_ONE;
  assign to_inc  = (to_cnt_reg >= TO_MAX) ? to_cnt_reg : to_cnt_reg + TO_ONE;

  assign code_index = {code_reg[2] | code_reg[3], code_reg[1] | code_reg[3]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      deb_cnt_reg <= '0;
      to_cnt_reg  <= '0;
      code_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      deb_cnt_reg <= deb_cnt_next;
      to_cnt_reg  <= to_cnt_next;
      code_reg    <= code_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    deb_cnt_next = deb_cnt_reg;
    to_cnt_next  = to_cnt_reg;
    code_next    = code_reg;
    timeout      = 1'b0;
    event_valid  = 1'b0;
    event_button = 2'd0;
    lamp         = 4'd0;
    busy         = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (arm) begin
          if (any_key) begin
            state_next   = WAIT_RELEASE;
            deb_cnt_next = '0;
          end else begin
            state_next  = WAIT_PRESS;
            to_cnt_next = '0;
          end
        end
      end

      WAIT_RELEASE: begin
        if (any_key) begin
          deb_cnt_next = '0;
        end else if (deb_cnt_reg >= DEB_LAST) begin
          state_next   = WAIT_PRESS;
          deb_cnt_next = '0;
          to_cnt_next  = '0;
        end else begin
          deb_cnt_next = deb_inc;
        end
      end

      WAIT_PRESS: begin
        to_cnt_next = to_inc;
        // A clean press takes priority over expiry on the same cycle.
        if (one_hot) begin
          code_next = pressed;
          if (DEBOUNCE_CYCLES == 1) begin
            state_next   = WAIT_UP;
            deb_cnt_next = '0;
          end else begin
            state_next   = DEBOUNCE_PRESS;
            deb_cnt_next = DEB_ONE;
          end
        end else if (to_cnt_reg >= TO_LAST) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end

      DEBOUNCE_PRESS: begin
        // to_cnt is frozen here so a bouncing key cannot stretch the time limit.
        if (pressed == code_reg) begin
          if (deb_cnt_reg >= DEB_LAST) begin
            state_next   = WAIT_UP;
            deb_cnt_next = '0;
          end else begin
            deb_cnt_next = deb_inc;
          end
        end else begin
          state_next = WAIT_PRESS;
        end
      end

      WAIT_UP: begin
        lamp = code_reg;
        if (any_key) begin
          deb_cnt_next = '0;
        end else if (deb_cnt_reg >= DEB_LAST) begin
          state_next   = REPORT;
          deb_cnt_next = '0;
        end else begin
          deb_cnt_next = deb_inc;
        end
      end

      REPORT: begin
        event_valid  = 1'b1;
        event_button = code_index;
        if (event_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_simon_input_ctrl.sv
// Directed bench for simon_input_ctrl with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20.
// Cycle numbers in comments count clock cycles after the arm cycle (cycle 0).
module tb_simon_input_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] pressed;
  logic       arm;
  logic       event_valid;
  logic [1:0] event_button;
  logic       event_ready;
  logic       timeout;
  logic [3:0] lamp;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  simon_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pressed     (pressed),
    .arm         (arm),
    .event_valid (event_valid),
    .event_button(event_button),
    .event_ready (event_ready),
    .timeout     (timeout),
    .lamp        (lamp),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle, apply inputs, then let combinational outputs settle.
  task automatic drive(input logic [3:0] p, input logic a, input logic r);
    @(posedge clk);
    #2;
    pressed     = p;
    arm         = a;
    event_ready = r;
    #1;
  endtask

  // Arm, press key for cycles 1..5, release from cycle 6; REPORT appears at cycle 10.
  task automatic run_to_report(input logic [3:0] key, input logic [1:0] idx,
                               input logic extra_arm, input string tag);
    drive(4'd0, 1'b1, 1'b0);
    chk({tag, "_idle_busy"}, busy, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(key, (i == 2) ? extra_arm : 1'b0, 1'b0);
      chk({tag, "_deb_lamp"}, lamp, 0);
    end
    drive(key, 1'b0, 1'b0);
    chk({tag, "_lamp_on"}, lamp, key);
    for (int i = 6; i <= 9; i++) begin
      drive(4'd0, 1'b0, 1'b0);
      chk({tag, "_rel_valid"}, event_valid, 0);
    end
    drive(4'd0, 1'b0, 1'b0);
    chk({tag, "_valid"}, event_valid, 1);
    chk({tag, "_button"}, event_button, idx);
    chk({tag, "_lamp_off"}, lamp, 0);
  endtask

  initial begin
    reset_n     = 1'b0;
    pressed     = 4'd0;
    arm         = 1'b0;
    event_ready = 1'b0;

    // Reset state
    drive(4'd0, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0);
    chk("rst_valid", event_valid, 0);
    chk("rst_button", event_button, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_lamp", lamp, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;

    // Clean press of key 2: held cycles 1..10, released at cycle 11
    drive(4'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 14; i++) begin
      drive((i <= 10) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
      chk("clean_busy", busy, 1);
      if (i == 4) chk("clean_lamp_pre", lamp, 0);
      if (i == 5) chk("clean_lamp_rise", lamp, 4'b0100);
      if (i == 14) chk("clean_lamp_hold", lamp, 4'b0100);
      chk("clean_no_valid", event_valid, 0);
    end
    for (int i = 15; i <= 19; i++) begin
      drive(4'd0, 1'b0, 1'b0);
      chk("clean_valid", event_valid, 1);
      chk("clean_button", event_button, 2);
      chk("clean_lamp_off", lamp, 0);
    end
    drive(4'd0, 1'b0, 1'b1);
    chk("clean_valid_acc", event_valid, 1);
    drive(4'd0, 1'b0, 1'b0);
    chk("clean_done_valid", event_valid, 0);
    chk("clean_done_busy", busy, 0);

    // Bounce on key 0, then rejected 0011, then key 3 held from cycle 12
    drive(4'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      if (i <= 8)       drive((((i - 1) / 2) % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
      else if (i <= 11) drive(4'b0011, 1'b0, 1'b0);
      else              drive(4'b1000, 1'b0, 1'b0);
      chk("bounce_lamp", lamp, 0);
      chk("bounce_timeout", timeout, 0);
    end
    drive(4'b1000, 1'b0, 1'b0);
    chk("bounce_lamp_on", lamp, 4'b1000);
    for (int i = 17; i <= 20; i++) drive(4'd0, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b1);
    chk("bounce_valid", event_valid, 1);
    chk("bounce_button", event_button, 3);
    drive(4'd0, 1'b0, 1'b0);
    chk("bounce_done", busy, 0);

    // Bounce must freeze, not reset, the timeout count: expiry lands on cycle 22
    drive(4'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 21; i++) begin
      drive((i <= 2) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
      chk("frz_timeout_low", timeout, 0);
    end
    drive(4'd0, 1'b0, 1'b0);
    chk("frz_timeout", timeout, 1);
    drive(4'd0, 1'b0, 1'b0);
    chk("frz_busy", busy, 0);

    // Timeout: no press for 20 cycles
    drive(4'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 19; i++) begin
      drive(4'd0, 1'b0, 1'b0);
      chk("to_low", timeout, 0);
    end
    drive(4'd0, 1'b0, 1'b0);
    chk("to_pulse", timeout, 1);
    chk("to_no_valid", event_valid, 0);
    drive(4'd0, 1'b0, 1'b0);
    chk("to_pulse_end", timeout, 0);
    chk("to_busy", busy, 0);
    chk("to_no_valid2", event_valid, 0);

    // Press on the expiry cycle wins
    drive(4'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 19; i++) drive(4'd0, 1'b0, 1'b0);
    drive(4'b0001, 1'b0, 1'b0);
    chk("exp_press_no_to", timeout, 0);
    for (int i = 21; i <= 23; i++) begin
      drive(4'b0001, 1'b0, 1'b0);
      chk("exp_busy", busy, 1);
      chk("exp_timeout", timeout, 0);
    end
    drive(4'b0001, 1'b0, 1'b0);
    chk("exp_lamp", lamp, 4'b0001);
    for (int i = 25; i <= 28; i++) drive(4'd0, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b1);
    chk("exp_valid", event_valid, 1);
    chk("exp_button", event_button, 0);
    drive(4'd0, 1'b0, 1'b0);
    chk("exp_done", busy, 0);

    // Key held at arm: wait for release, then press key 0 from cycle 35
    drive(4'b0010, 1'b1, 1'b0);
    for (int i = 1; i <= 34; i++) begin
      drive((i <= 30) ? 4'b0010 : 4'b0000, 1'b0, 1'b0);
      chk("held_busy", busy, 1);
      chk("held_timeout", timeout, 0);
      chk("held_lamp", lamp, 0);
    end
    for (int i = 35; i <= 38; i++) drive(4'b0001, 1'b0, 1'b0);
    chk("held_lamp_pre", lamp, 0);
    drive(4'b0001, 1'b0, 1'b0);
    chk("held_lamp_on", lamp, 4'b0001);
    for (int i = 40; i <= 43; i++) drive(4'd0, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b1);
    chk("held_valid", event_valid, 1);
    chk("held_button", event_button, 0);
    drive(4'd0, 1'b0, 1'b0);
    chk("held_done", busy, 0);

    // Arm while busy: pulses in DEBOUNCE_PRESS and REPORT are ignored
    run_to_report(4'b0010, 2'd1, 1'b1, "busyarm");
    drive(4'd0, 1'b1, 1'b0);
    chk("busyarm_valid", event_valid, 1);
    drive(4'd0, 1'b0, 1'b1);
    chk("busyarm_button", event_button, 1);
    drive(4'd0, 1'b0, 1'b0);
    chk("busyarm_idle", busy, 0);
    chk("busyarm_no_valid", event_valid, 0);
    drive(4'd0, 1'b0, 1'b0);
    chk("busyarm_no_queue", busy, 0);

    // Reset asserted mid-REPORT, then a fresh entry
    run_to_report(4'b1000, 2'd3, 1'b0, "mid");
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", event_valid, 0);
    chk("midrst_button", event_button, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_lamp", lamp, 0);
    chk("midrst_timeout", timeout, 0);
    drive(4'd0, 1'b0, 1'b0);
    chk("midrst_hold", busy, 0);
    reset_n = 1'b1;
    run_to_report(4'b0010, 2'd1, 1'b0, "after");
    drive(4'd0, 1'b0, 1'b1);
    chk("after_valid_acc", event_valid, 1);
    drive(4'd0, 1'b0, 1'b0);
    chk("after_done", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/simon_input_ctrl.md
Name: simon_input_ctrl

Overview:
Turns a player's key press into a single clean event for the Simon game FSM. Sits between the key synchronizer (active-high, synchronized `pressed[3:0]`) and the game sequencer. When armed, it waits for exactly one key, debounces both the press and the release, and drives the LED echo while the key is held. It then delivers the key index over a valid/ready handshake, or raises a timeout pulse if the player does not respond.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required for press and for release (10 ms at 50 MHz); minimum 1
TIMEOUT_CYCLES, 150000000, cycles allowed in WAIT_PRESS before timeout (3 s at 50 MHz); minimum 2

Ports:
clk  input  1  system clock, all logic on posedge
reset_n  input  1  asynchronous active-low reset
pressed  input  4  synchronized key state, active high, one bit per key
arm  input  1  one-cycle request from game FSM to collect one entry
event_valid  output  1  entry available
event_button  output  2  binary index of the accepted key (bit0=0 … bit3=3)
event_ready  input  1  game FSM accepts the entry
timeout  output  1  one-cycle pulse: no valid press within TIMEOUT_CYCLES
lamp  output  4  one-hot echo of the debounced held key, for the LEDs
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE; all counters 0; latched code 0.
  - event_valid=0, event_button=0, timeout=0, lamp=0, busy=0.
  - Reset asserted mid-operation aborts the entry; no event or timeout is emitted.
- Counters: `deb_cnt` is $clog2(DEBOUNCE_CYCLES+1) bits; `to_cnt` is $clog2(TIMEOUT_CYCLES+1) bits; both saturating, never wrap.
- IDLE:
  - arm=1 with pressed≠0 -> WAIT_RELEASE, deb_cnt=0.
  - arm=1 with pressed=0 -> WAIT_PRESS, to_cnt=0.
  - arm in any other state is ignored (no queuing).
- WAIT_RELEASE (key still held from a previous round):
  - pressed=0 increments deb_cnt; pressed≠0 clears it.
  - deb_cnt reaches DEBOUNCE_CYCLES -> WAIT_PRESS, to_cnt=0.
  - No timeout counting in this state.
- WAIT_PRESS:
  - to_cnt increments every cycle.
  - pressed one-hot -> DEBOUNCE_PRESS; latch code=pressed; deb_cnt=1.
  - pressed multi-hot or zero -> stay (multi-key presses are rejected).
  - to_cnt = TIMEOUT_CYCLES-1 with no one-hot press -> timeout=1 for exactly one cycle; IDLE next.
  - A one-hot press on the expiry cycle wins: no timeout.
- DEBOUNCE_PRESS:
  - to_cnt holds.
  - pressed=code increments deb_cnt; reaching DEBOUNCE_CYCLES -> WAIT_UP, lamp=code, deb_cnt=0.
  - Any other pressed value -> WAIT_PRESS; to_cnt resumes from its held value, so bounce does not extend the time limit.
- WAIT_UP:
  - lamp=code.
  - pressed=0 increments deb_cnt; any nonzero pressed clears it, including a second key.
  - deb_cnt reaches DEBOUNCE_CYCLES -> REPORT, lamp=0.
- REPORT:
  - event_valid=1; event_button=index(code); both stable until accepted.
  - event_valid & event_ready on the same edge -> IDLE, event_valid=0 next cycle.
  - event_ready outside REPORT is ignored.
- busy=1 in every state except IDLE; timeout and event_valid are never high together.
- Latency with key held steady from cycle t in WAIT_PRESS:
  - lamp rises at t+DEBOUNCE_CYCLES.
  - If released at cycle r, event_valid rises at r+DEBOUNCE_CYCLES.

Test Plan (bench uses DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20):
- Reset mid-REPORT: assert reset_n=0 while event_valid=1 -> all outputs 0 immediately; state IDLE; a later arm works normally.
- Clean press: arm; pressed=4'b0100 for 10 cycles, then 0 -> lamp=4'b0100 from 4 cycles after press until release; event_valid rises 4 cycles after release with event_button=2. Holding event_ready=0 for 5 cycles -> event_valid and event_button stay stable; event_ready=1 -> IDLE, busy=0.
- Bounce and multi-key: arm; pressed toggles 0001/0000 every 2 cycles, then 0011 for 3 cycles, then 1000 held -> no lamp during bounce or 0011; final event_button=3; to_cnt not reset by bounce.
- Timeout: arm; pressed=0 for 20 cycles -> timeout is a single-cycle pulse on cycle 20 after arm; busy=0 next; no event_valid. Second run with pressed=0001 on the expiry cycle -> no timeout; entry proceeds.
- Held at arm: pressed=0010 when arm pulses -> WAIT_RELEASE; release for 4 cycles, then press 0001 -> event_button=0; no timeout accrues while held.
- Arm while busy: pulse arm during DEBOUNCE_PRESS and REPORT -> ignored; exactly one event per accepted arm.
